// File: rtl/avr_adc_spi_master_if.sv
// Request/response and SPI pin bundle for avr_adc_spi_master.
// The master modport is the SPI master itself; slave is the FPGA/bench side.
interface avr_adc_spi_master_if;
  logic        start;
  logic [9:0]  sample;
  logic [3:0]  channel_in;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic        spi_ss;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, sample, channel_in, spi_miso,
    output busy, done, rx_data, spi_ss, spi_sck, spi_mosi
  );

  modport slave (
    output start, sample, channel_in, spi_miso,
    input  busy, done, rx_data, spi_ss, spi_sck, spi_mosi
  );
endinterface

// File: rtl/avr_adc_spi_master.sv
// SPI mode-0 master sending one 16-bit ADC sample frame per start request.
// Define AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN to build the MISO receive shifter.
module avr_adc_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SS_GAP  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  avr_adc_spi_master_if.master bus
);

  localparam int unsigned HalfW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW  = $clog2(SS_GAP + 1);
  localparam logic [HalfW-1:0] HalfMax = HalfW'(CLK_DIV - 1);
  localparam logic [GapW-1:0]  GapMax  = GapW'(SS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e             state_q;
  logic               ss_q;
  logic               sck_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        tx_q;
  logic [HalfW-1:0]   div_q;
  logic [4:0]         bit_q;
  logic [GapW-1:0]    gap_q;
`ifdef AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN
  logic [15:0]        rx_shift_q;
  logic [15:0]        rx_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
`ifdef AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN
      rx_shift_q <= '0;
      rx_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            tx_q    <= {bus.sample[7:0], bus.channel_in, 2'b00, bus.sample[9:8]};
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (div_q == HalfMax) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= StShift;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StShift: begin
          if (div_q == HalfMax) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
`ifdef AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN
              rx_shift_q <= {rx_shift_q[14:0], bus.spi_miso};
`endif
            end else begin
              // Falling edge: next MOSI bit appears while SCK is low.
              sck_q <= 1'b0;
              tx_q  <= {tx_q[14:0], 1'b0};
              if (bit_q == 5'd15) begin
                bit_q   <= '0;
                state_q <= StHold;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StHold: begin
          if (div_q == HalfMax) begin
            div_q   <= '0;
            ss_q    <= 1'b1;
            done_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= StGap;
`ifdef AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN
            rx_q <= rx_shift_q;
`endif
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapMax) begin
            gap_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // tx_q is empty after the 16th shift, so MOSI rests low outside frames.
  assign bus.spi_ss   = ss_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = tx_q[15];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef AVR_ADC_SPI_MASTER_MISO_CAPTURE_EN
  assign bus.rx_data = rx_q;
`else
  logic unused_miso;
  assign unused_miso = bus.spi_miso;
  assign bus.rx_data = 16'hFFFF;
`endif

endmodule
